// File: rtl/stdp_pkg.sv
// Shared defaults for the LIF neuron pair with STDP learning.
// Also holds the trace counter width and the trace update helper.
package stdp_pkg;

  localparam int W_DEF          = 8;
  localparam int WW_DEF         = 4;
  localparam int THRESH_DEF     = 128;
  localparam int LEAK_SHIFT_DEF = 3;
  localparam int REFRAC_DEF     = 2;
  localparam int WIN_DEF        = 7;
  localparam int W_INIT_DEF     = 8;
  localparam int TW             = 4;

  // A trace restarts at zero after its spike and otherwise ages up to the window edge.
  function automatic logic [TW-1:0] trace_next(input logic [TW-1:0] t,
                                               input logic            spk,
                                               input logic [TW-1:0] win);
    if (spk) return '0;
    return (t < win) ? t + 1'b1 : win;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with saturating membrane, one-cycle spike
// pulse and a fixed refractory period during which input current is ignored.
module lif_neuron #(
  parameter int W          = 8,
  parameter int THRESH     = 128,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] cur,
  output logic [W-1:0] state,
  output logic         spk
);

  localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [W-1:0]  THRESH_V = W'(THRESH);
  localparam logic [RW-1:0] REFRAC_V = RW'(REFRAC);

  logic [W-1:0]  state_q, state_d;
  logic          spk_q, spk_d;
  logic [RW-1:0] refrac_q, refrac_d;
  logic [W:0]    sum;

  always_comb begin
    state_d  = state_q;
    spk_d    = spk_q;
    refrac_d = refrac_q;
    // One extra bit catches overflow of the leak-plus-current sum.
    sum = {1'b0, state_q} - {1'b0, state_q >> LEAK_SHIFT} + {1'b0, cur};
    if (ena) begin
      if (state_q >= THRESH_V) begin
        state_d  = '0;
        spk_d    = 1'b1;
        refrac_d = REFRAC_V;
      end else if (refrac_q != '0) begin
        state_d  = '0;
        spk_d    = 1'b0;
        refrac_d = refrac_q - 1'b1;
      end else begin
        spk_d   = 1'b0;
        state_d = sum[W] ? '1 : sum[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= '0;
      spk_q    <= 1'b0;
      refrac_q <= '0;
    end else begin
      state_q  <= state_d;
      spk_q    <= spk_d;
      refrac_q <= refrac_d;
    end
  end

  assign state = state_q;
  assign spk   = spk_q;

endmodule

// File: rtl/lif_stdp_pair.sv
// Pre/post LIF neuron pair joined by one plastic synapse; pair-based STDP
// uses saturating spike-age traces to decide potentiation or depression.
module lif_stdp_pair
  import stdp_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int WW         = WW_DEF,
  parameter int THRESH     = THRESH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int REFRAC     = REFRAC_DEF,
  parameter int WIN        = WIN_DEF,
  parameter int W_INIT     = W_INIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          learn_en,
  input  logic [W-1:0]  cur_pre,
  output logic          spk_pre,
  output logic          spk_post,
  output logic [W-1:0]  state_post,
  output logic [WW-1:0] weight
);

  localparam logic [TW-1:0] WIN_V    = TW'(WIN);
  localparam logic [WW-1:0] W_INIT_V = WW'(W_INIT);

  logic [W-1:0]  state_pre;
  logic [W-1:0]  cur_post;
  logic [TW-1:0] t_pre_q, t_pre_d, t_post_q, t_post_d;
  logic [WW-1:0] weight_q, weight_d;
  logic          ltp, ltd;

  lif_neuron #(.W(W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)) u_pre (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cur(cur_pre), .state(state_pre), .spk(spk_pre)
  );

  lif_neuron #(.W(W), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)) u_post (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cur(cur_post), .state(state_post), .spk(spk_post)
  );

  always_comb begin
    cur_post = spk_pre ? (W'(weight_q) << (W - WW)) : '0;
    ltp = learn_en & spk_post & ~spk_pre & (t_pre_q < WIN_V);
    ltd = learn_en & spk_pre & ~spk_post & (t_post_q < WIN_V);
    t_pre_d  = t_pre_q;
    t_post_d = t_post_q;
    weight_d = weight_q;
    if (ena) begin
      t_pre_d  = trace_next(t_pre_q, spk_pre, WIN_V);
      t_post_d = trace_next(t_post_q, spk_post, WIN_V);
      if (ltp && (weight_q != '1))
        weight_d = weight_q + 1'b1;
      else if (ltd && (weight_q != '0))
        weight_d = weight_q - 1'b1;
    end
  end

  // Traces start saturated so nothing learned before reset can pair with new spikes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_pre_q  <= WIN_V;
      t_post_q <= WIN_V;
      weight_q <= W_INIT_V;
    end else begin
      t_pre_q  <= t_pre_d;
      t_post_q <= t_post_d;
      weight_q <= weight_d;
    end
  end

  assign weight = weight_q;

endmodule

// File: tb/tb_lif_stdp_pair.sv
// Self-checking bench for lif_stdp_pair: a per-cycle reference model feeds a
// scoreboard, and each scenario task adds its own targeted checks.
module tb_lif_stdp_pair;

  localparam int WIN    = 7;
  localparam int W_INIT = 8;

  typedef struct packed {
    logic       spk_pre;
    logic       spk_post;
    logic [7:0] state_pre;
    logic [7:0] state_post;
    logic [3:0] weight;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       learn_en;
  logic [7:0] cur_pre;
  logic       spk_pre;
  logic       spk_post;
  logic [7:0] state_post;
  logic [3:0] weight;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  exp_t sb[$];

  int m_pre_s, m_pre_k, m_pre_r;
  int m_post_s, m_post_k, m_post_r;
  int m_tpre, m_tpost, m_w;

  lif_stdp_pair dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .learn_en(learn_en), .cur_pre(cur_pre),
    .spk_pre(spk_pre), .spk_post(spk_post), .state_post(state_post), .weight(weight)
  );

  always #5 clk = ~clk;

  // Reference neuron: threshold check first, then refractory hold, then leaky integration.
  task automatic model_neuron(input int s, input int k, input int r, input int c,
                              output int ns, output int nk, output int nr);
    int sum;
    if (s >= 128) begin
      ns = 0; nk = 1; nr = 2;
    end else if (r > 0) begin
      ns = 0; nk = 0; nr = r - 1;
    end else begin
      sum = s - (s / 8) + c;
      ns = (sum > 255) ? 255 : sum;
      nk = 0; nr = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic l, input logic [7:0] c);
    int ops, opk, opr, oqs, oqk, oqr, otp, otq, ow;
    ops = m_pre_s;  opk = m_pre_k;  opr = m_pre_r;
    oqs = m_post_s; oqk = m_post_k; oqr = m_post_r;
    otp = m_tpre;   otq = m_tpost;  ow = m_w;
    if (!r) begin
      m_pre_s = 0; m_pre_k = 0; m_pre_r = 0;
      m_post_s = 0; m_post_k = 0; m_post_r = 0;
      m_tpre = WIN; m_tpost = WIN; m_w = W_INIT;
    end else if (e) begin
      model_neuron(ops, opk, opr, int'(c), m_pre_s, m_pre_k, m_pre_r);
      model_neuron(oqs, oqk, oqr, (opk == 1) ? ow * 16 : 0, m_post_s, m_post_k, m_post_r);
      m_tpre  = (opk == 1) ? 0 : ((otp < WIN) ? otp + 1 : WIN);
      m_tpost = (oqk == 1) ? 0 : ((otq < WIN) ? otq + 1 : WIN);
      if (l && oqk == 1 && opk == 0 && otp < WIN) m_w = (ow < 15) ? ow + 1 : 15;
      else if (l && opk == 1 && oqk == 0 && otq < WIN) m_w = (ow > 0) ? ow - 1 : 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.spk_pre    = 1'(m_pre_k);
    e.spk_post   = 1'(m_post_k);
    e.state_pre  = 8'(m_pre_s);
    e.state_post = 8'(m_post_s);
    e.weight     = 4'(m_w);
    return e;
  endfunction

  // One clock: predict, push, clock, then pop and compare against the DUT.
  task automatic step();
    exp_t e, obs;
    model_step(rst_n, ena, learn_en, cur_pre);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    e   = sb.pop_front();
    obs = {spk_pre, spk_post, dut.state_pre, state_post, weight};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("[TB] FAIL scoreboard cyc=%0d got spk_pre=%b spk_post=%b state_pre=%0d state_post=%0d weight=%0d expected %b %b %0d %0d %0d",
               cyc, obs.spk_pre, obs.spk_post, obs.state_pre, obs.state_post, obs.weight,
               e.spk_pre, e.spk_post, e.state_pre, e.state_post, e.weight);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1; learn_en = 1'b0; cur_pre = 8'd0;
    do_reset(2);
    n_checks++;
    if ({spk_pre, spk_post, state_post} !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got spk_pre=%b spk_post=%b state_post=%0d expected 0 0 0", spk_pre, spk_post, state_post);
    end
    n_checks++;
    if (weight !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL reset_weight got %0d expected 8", weight);
    end
    n_checks++;
    if (dut.t_pre_q !== 4'd7 || dut.t_post_q !== 4'd7) begin
      n_fail++;
      $display("[TB] FAIL reset_traces got t_pre=%0d t_post=%0d expected 7 7", dut.t_pre_q, dut.t_post_q);
    end
  endtask

  task automatic test_idle();
    int spikes;
    spikes = 0;
    learn_en = 1'b1; cur_pre = 8'd0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (spk_pre || spk_post) spikes++;
    end
    n_checks++;
    if (spikes !== 0) begin
      n_fail++;
      $display("[TB] FAIL idle_spikes got %0d expected 0", spikes);
    end
    n_checks++;
    if (weight !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL idle_weight got %0d expected 8", weight);
    end
  endtask

  task automatic test_fire();
    learn_en = 1'b0; cur_pre = 8'd0;
    do_reset(1);
    cur_pre = 8'd255;
    step();
    n_checks++;
    if (dut.state_pre !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL fire_state_pre got %0d expected 255", dut.state_pre);
    end
    step();
    n_checks++;
    if (spk_pre !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fire_first_spike got %b expected 1", spk_pre);
    end
    // Spikes recur every REFRAC+2 = 4 cycles: cycles 2, 6, 10, 14.
    for (int k = 3; k <= 14; k++) begin
      step();
      n_checks++;
      if (spk_pre !== ((k % 4) == 2)) begin
        n_fail++;
        $display("[TB] FAIL fire_period k=%0d got %b expected %b", k, spk_pre, (k % 4) == 2);
      end
    end
  endtask

  // Single pre spike at cycle 2, then a second pre spike at cycle 6 for depression.
  task automatic pair_sequence(input logic learn, input int w_ltp, input int w_ltd);
    cur_pre = 8'd0; learn_en = learn;
    do_reset(1);
    cur_pre = 8'd255;
    step();
    cur_pre = 8'd0;
    step();
    n_checks++;
    if (spk_pre !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pair_pre_spike got %b expected 1", spk_pre);
    end
    step();
    n_checks++;
    if (state_post !== 8'd128) begin
      n_fail++;
      $display("[TB] FAIL pair_state_post got %0d expected 128", state_post);
    end
    step();
    n_checks++;
    if (spk_post !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pair_post_spike got %b expected 1", spk_post);
    end
    cur_pre = 8'd255;
    step();
    n_checks++;
    if (weight !== 4'(w_ltp)) begin
      n_fail++;
      $display("[TB] FAIL pair_ltp_weight got %0d expected %0d", weight, w_ltp);
    end
    cur_pre = 8'd0;
    step();
    step();
    n_checks++;
    if (weight !== 4'(w_ltd)) begin
      n_fail++;
      $display("[TB] FAIL pair_ltd_weight got %0d expected %0d", weight, w_ltd);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_ltp_ltd();
    pair_sequence(1'b1, 9, 8);
  endtask

  task automatic test_gating();
    pair_sequence(1'b0, 8, 8);
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 0;
    cur_pre = 8'd0; learn_en = 1'b0;
    do_reset(1);
    cur_pre = 8'd255;
    for (int i = 0; i < 200 && !found; i++) begin
      learn_en = 1'(m_post_k);
      step();
      if (m_w == 12 && m_post_r != 0) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_setup got no refractory cycle with weight 12 expected one within 200 cycles");
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({spk_pre, spk_post, dut.state_pre, state_post, weight} !== {1'b0, 1'b0, 8'd0, 8'd0, 4'd8}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_state got spk=%b%b state_pre=%0d state_post=%0d weight=%0d expected 00 0 0 8",
               spk_pre, spk_post, dut.state_pre, state_post, weight);
    end
    n_checks++;
    if (dut.t_pre_q !== 4'd7 || dut.t_post_q !== 4'd7 || dut.u_post.refrac_q !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_traces got t_pre=%0d t_post=%0d refrac=%0d expected 7 7 0",
               dut.t_pre_q, dut.t_post_q, dut.u_post.refrac_q);
    end
  endtask

  task automatic test_ltp_saturation();
    cur_pre = 8'd255;
    for (int i = 0; i < 80; i++) begin
      learn_en = 1'(m_post_k);
      step();
    end
    n_checks++;
    if (weight !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL ltp_saturation got %0d expected 15", weight);
    end
  endtask

  task automatic test_ltd_decay();
    cur_pre = 8'd255;
    for (int i = 0; i < 120; i++) begin
      learn_en = 1'(m_pre_k == 1 && m_post_k == 0);
      step();
    end
    n_checks++;
    if (!(weight < 4'd15)) begin
      n_fail++;
      $display("[TB] FAIL ltd_decay got %0d expected below 15", weight);
    end
  endtask

  task automatic test_freeze();
    exp_t snap, obs;
    cur_pre = 8'd255; learn_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    snap = model_out();
    ena = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cur_pre = 8'(i * 37);
      step();
      obs = {spk_pre, spk_post, dut.state_pre, state_post, weight};
      n_checks++;
      if (obs !== snap) begin
        n_fail++;
        $display("[TB] FAIL freeze i=%0d got %h expected %h", i, obs, snap);
      end
    end
    ena = 1'b1; cur_pre = 8'd255;
    for (int i = 0; i < 10; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; learn_en = 1'b0; cur_pre = 8'd0;
    #2;
    test_reset();
    test_idle();
    test_fire();
    test_ltp_ltd();
    test_gating();
    test_mid_reset();
    test_ltp_saturation();
    test_ltd_decay();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
